// File: rtl/conv_interleaver_commutator.sv
// Byte-wide Forney convolutional interleaver: commutates accepted bytes over BRANCHES
// branches, branch j delaying by j*DEPTH_M of its own visits, through a 1-deep output register.
module conv_interleaver_commutator #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned BRANCHES = 12,
  parameter int unsigned DEPTH_M  = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sync,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sync,
  output logic [3:0]       out_branch,
  output logic             sync_err
);

  logic [3:0]       r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sync;
  logic [3:0]       r_out_branch;
  logic             r_sync_err;

  logic             w_accept;
  logic             w_misalign;
  logic [3:0]       w_branch;
  logic [3:0]       w_cnt_next;
  logic [BRANCHES-1:0][WIDTH-1:0] w_rd_data;

  assign in_ready   = out_ready | ~r_out_valid;
  assign w_accept   = in_valid & in_ready;
  // A sync byte arriving off branch 0 realigns the commutator: it is passed through on
  // branch 0 and the next byte continues on branch 1.
  assign w_misalign = in_sync & (r_cnt != '0);
  assign w_branch   = w_misalign ? '0 : r_cnt;

  always_comb begin
    w_cnt_next = r_cnt + 4'd1;
    if (w_misalign)
      w_cnt_next = 4'd1;
    else if (r_cnt == 4'(BRANCHES - 1))
      w_cnt_next = '0;
  end

  assign w_rd_data[0] = in_data;

  for (genvar b = 1; b < BRANCHES; b++) begin : g_branch
    localparam int unsigned DEP = b * DEPTH_M;
    localparam int unsigned PW  = (DEP > 1) ? $clog2(DEP) : 1;

    logic [WIDTH-1:0] r_mem [DEP];
    logic [PW-1:0]    r_ptr;
    logic             w_sel;

    assign w_sel        = w_accept && (w_branch == 4'(b));
    assign w_rd_data[b] = r_mem[r_ptr];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ptr <= '0;
        for (int unsigned i = 0; i < DEP; i++) r_mem[i] <= '0;
      end else if (w_sel) begin
        r_mem[r_ptr] <= in_data;
        r_ptr        <= (r_ptr == PW'(DEP - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sync   <= 1'b0;
      r_out_branch <= '0;
      r_sync_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt        <= w_cnt_next;
      r_out_valid  <= 1'b1;
      r_out_data   <= w_rd_data[w_branch];
      r_out_sync   <= in_sync;
      r_out_branch <= w_branch;
      r_sync_err   <= w_misalign;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
      r_sync_err   <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sync   = r_out_sync;
  assign out_branch = r_out_branch;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_conv_interleaver_commutator.sv
// Directed bench for conv_interleaver_commutator: reset, passthrough, delay law,
// backpressure, sync realignment and mid-stream reset.
module tb_conv_interleaver_commutator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sync;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sync;
  logic [3:0] out_branch;
  logic       sync_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  conv_interleaver_commutator #(.WIDTH(8), .BRANCHES(12), .DEPTH_M(17)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sync(out_sync), .out_branch(out_branch), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given input drive; outputs observed 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic s);
    in_valid = v; in_data = d; in_sync = s;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] exp_byte(input int unsigned n);
    int unsigned j;
    j = n % 12;
    return (n >= 204 * j) ? 8'((n - 204 * j) % 256) : 8'h00;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_stream(input int unsigned count, input int bp_at);
    for (int unsigned n = 0; n < count; n++) begin
      step(1'b1, 8'(n % 256), (n % 204) == 0);
      check_eq("stream_valid", out_valid, 1'b1);
      check_eq("stream_data", out_data, exp_byte(n));
      check_eq("stream_branch", out_branch, n % 12);
      check_eq("stream_sync", out_sync, (n % 204) == 0);
      check_eq("stream_err", sync_err, 1'b0);
      if (bp_at >= 0 && n == int'(bp_at)) begin
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'((n + 1) % 256); in_sync = ((n + 1) % 204) == 0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check_eq("bp_ready", in_ready, 1'b0);
          @(posedge clk); #1;
          check_eq("bp_valid", out_valid, 1'b1);
          check_eq("bp_data", out_data, exp_byte(n));
          check_eq("bp_branch", out_branch, n % 12);
        end
        out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_sync = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // reset held while traffic is driven
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'hC3, 1'b1);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_data", out_data, 8'h00);
      check_eq("rst_ready", in_ready, 1'b1);
      check_eq("rst_err", sync_err, 1'b0);
    end
    reset = 1'b1; #1;

    step(1'b1, 8'hA5, 1'b0);
    check_eq("pt_valid", out_valid, 1'b1);
    check_eq("pt_data", out_data, 8'hA5);
    check_eq("pt_branch", out_branch, 4'd0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("idle_valid", out_valid, 1'b0);

    // misaligned sync on 4th byte
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    check_eq("mis_pre_branch", out_branch, 4'd2);
    step(1'b1, 8'h3C, 1'b1);
    check_eq("mis_branch", out_branch, 4'd0);
    check_eq("mis_data", out_data, 8'h3C);
    check_eq("mis_err", sync_err, 1'b1);
    check_eq("mis_sync", out_sync, 1'b1);
    step(1'b1, 8'h44, 1'b0);
    check_eq("mis_next_branch", out_branch, 4'd1);
    check_eq("mis_next_data", out_data, 8'h00);
    check_eq("mis_err_pulse", sync_err, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_eq("sync_novalid_err", sync_err, 1'b0);
    check_eq("sync_novalid_valid", out_valid, 1'b0);

    do_reset();
    run_stream(2448, 1500);

    // mid-stream reset, then everything must look like a fresh start
    do_reset();
    run_stream(1000, -1);
    do_reset();
    step(1'b1, 8'hA5, 1'b0);
    check_eq("pt2_data", out_data, 8'hA5);
    check_eq("pt2_branch", out_branch, 4'd0);
    do_reset();
    run_stream(2448, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
